// File: rtl/hex_key_emulator_pkg.sv
// Shared types and key-geometry helpers for the hex keypad emulators.
package hex_key_emulator_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [1:0] key_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return code[1:0];
  endfunction

  function automatic logic [15:0] key_onehot(input logic [3:0] code);
    return 16'(1) << code;
  endfunction

  // Clamp a cycle-count parameter into the counter range with a lower floor.
  function automatic logic [CNT_W-1:0] sat_cnt(input int value, input int floor);
    int v;
    v = (value < floor) ? floor : value;
    if (v > (1 << CNT_W) - 1) begin
      v = (1 << CNT_W) - 1;
    end
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/hex_key_emulator_if.sv
// Key-code valid/ready handshake between a key source and the emulator.
interface hex_key_emulator_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_valid, input  key_ready);
  modport slave  (input  key_code, input  key_valid, output key_ready);
endinterface

// File: rtl/hex_key_emulator_key_matrix_drive.sv
// Closed-contact path of one key: returns Col[c] on Row[r]; purely combinational.
module key_matrix_drive
  import hex_key_emulator_pkg::*;
(
  input  logic                contact,
  input  logic [3:0]          code,
  input  logic [KEY_COLS-1:0] col,
  output logic [KEY_ROWS-1:0] row
);

  always_comb begin
    row                = '0;
    row[key_row(code)] = contact & col[key_col(code)];
  end

endmodule

// File: rtl/hex_key_emulator.sv
// Keypad-side key presser: one key per handshake, timed hold then release gap (KEY_BOUNCE_EN adds contact bounce).
// Latency: contact closes the cycle after accept; Row follows Col combinationally while closed.
// Backpressure: key_ready is low for the whole press+gap; key_valid is ignored while busy.
module hex_key_emulator
  import hex_key_emulator_pkg::*;
#(
  parameter int HOLD_CYCLES   = 6,
  parameter int GAP_CYCLES    = 2,
  parameter int BOUNCE_CYCLES = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  hex_key_emulator_if.slave     key_if,
  input  logic [KEY_COLS-1:0]   Col,
  output logic [KEY_ROWS-1:0]   Row,
  output logic [15:0]           key_onehot,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_W-1:0] HOLD_LD = sat_cnt(HOLD_CYCLES, 1);
  localparam logic [CNT_W-1:0] GAP_LD  = sat_cnt(GAP_CYCLES, 0);
`ifdef KEY_BOUNCE_EN
  localparam logic [CNT_W-1:0] BNC_RAW = sat_cnt(BOUNCE_CYCLES, 0);
  localparam logic [CNT_W-1:0] BNC_LD  = (BNC_RAW > HOLD_LD) ? HOLD_LD : BNC_RAW;
`else
  localparam logic [CNT_W-1:0] BNC_LD  = '0;
`endif
  // The counter runs HOLD_LD..1 in PRESS; values above this edge are bounce cycles.
  localparam logic [CNT_W-1:0] BOUNCE_EDGE = HOLD_LD - BNC_LD;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             done_q, done_d;

  logic in_press;
  logic in_bounce;
  logic elapsed_odd;
  logic contact;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_if.key_valid) begin
          state_d = PRESS;
          cnt_d   = HOLD_LD;
          code_d  = key_if.key_code;
        end
      end
      PRESS: begin
        if (cnt_q <= CNT_W'(1)) begin
          if (GAP_LD == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  // Parity of cycles elapsed in PRESS, so bounce starts closed for any hold length.
  assign in_press    = (state_q == PRESS);
  assign in_bounce   = in_press && (cnt_q > BOUNCE_EDGE);
  assign elapsed_odd = cnt_q[0] ^ HOLD_LD[0];
  assign contact     = in_press & ~(in_bounce & elapsed_odd);

  assign key_if.key_ready = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign key_onehot       = contact ? hex_key_emulator_pkg::key_onehot(code_q) : 16'h0000;

  key_matrix_drive u_drive (
    .contact (contact),
    .code    (code_q),
    .col     (Col),
    .row     (Row)
  );

endmodule
